// File: rtl/silife_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : silife_gen_scheduler
// Brief    : Generation scheduler for the silife grid; emits single-cycle grid
//            advance pulses from free-run, single-step and burst sources.
// Option   : define SILIFE_GEN_FRAME_LOCK_EN to enable display frame lock.
// Revision : 1.0
// ============================================================================
module silife_gen_scheduler #(
  parameter int PERIOD_WIDTH = 24,
  parameter int BURST_WIDTH  = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_burst_start,
  input  logic [BURST_WIDTH-1:0]  i_burst_len,
  input  logic                    i_abort,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic                    i_frame_lock,
  input  logic                    i_sync_busy,
  input  logic                    i_display_busy,
  input  logic                    i_clear_count,
  output logic                    o_grid_enable,
  output logic                    o_frame_req,
  output logic [COUNT_WIDTH-1:0]  o_gen_count,
  output logic [BURST_WIDTH-1:0]  o_burst_remaining,
  output logic                    o_busy
);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_WAIT_TICK  = 3'd1;
  localparam logic [2:0] c_WAIT_SYNC  = 3'd2;
  localparam logic [2:0] c_STEP       = 3'd3;
`ifdef SILIFE_GEN_FRAME_LOCK_EN
  localparam logic [2:0] c_FRAME_RISE = 3'd4;
  localparam logic [2:0] c_FRAME_FALL = 3'd5;
`endif

  logic [2:0]              r_state;
  logic [2:0]              w_next_state;
  logic                    r_pending;
  logic                    r_src_step;
  logic [PERIOD_WIDTH-1:0] r_period_cnt;
  logic [PERIOD_WIDTH-1:0] w_period_last;
  logic                    r_grid_enable;
  logic                    r_busy;
  logic [COUNT_WIDTH-1:0]  r_gen_count;
  logic [BURST_WIDTH-1:0]  r_burst_remaining;
  logic                    w_period_active;
  logic                    w_stall;

`ifdef SILIFE_GEN_FRAME_LOCK_EN
  logic                    r_frame_req;
  assign w_stall     = i_sync_busy || (i_frame_lock && i_display_busy);
  assign o_frame_req = r_frame_req;
`else
  logic                    w_unused_frame;
  assign w_unused_frame = i_frame_lock ^ i_display_busy;
  assign w_stall        = i_sync_busy;
  assign o_frame_req    = 1'b0;
`endif

  // A period of zero behaves as a period of one.
  assign w_period_last   = (i_period == '0) ? '0 : (i_period - PERIOD_WIDTH'(1));
  assign w_period_active = i_run || (r_burst_remaining != '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (!i_abort) begin
          if (r_pending)            w_next_state = c_WAIT_SYNC;
          else if (w_period_active) w_next_state = c_WAIT_TICK;
        end
      end
      c_WAIT_TICK: begin
        if (i_abort)                             w_next_state = c_IDLE;
        else if (r_pending)                      w_next_state = c_WAIT_SYNC;
        else if (!w_period_active)               w_next_state = c_IDLE;
        else if (r_period_cnt == w_period_last)  w_next_state = c_WAIT_SYNC;
      end
      c_WAIT_SYNC: begin
        if (i_abort)       w_next_state = c_IDLE;
        else if (!w_stall) w_next_state = c_STEP;
      end
`ifdef SILIFE_GEN_FRAME_LOCK_EN
      c_STEP:       w_next_state = r_frame_req ? c_FRAME_RISE : c_IDLE;
      c_FRAME_RISE: if (i_display_busy)  w_next_state = c_FRAME_FALL;
      c_FRAME_FALL: if (!i_display_busy) w_next_state = c_IDLE;
`else
      c_STEP:       w_next_state = c_IDLE;
`endif
      default:      w_next_state = c_IDLE;
    endcase
  end

  // Pulse outputs are registered from the next state so they coincide with STEP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_grid_enable <= 1'b0;
      r_busy        <= 1'b0;
      r_src_step    <= 1'b0;
      r_period_cnt  <= '0;
    end else begin
      r_state       <= w_next_state;
      r_grid_enable <= (w_next_state == c_STEP);
      r_busy        <= (w_next_state != c_IDLE);
      if ((w_next_state == c_WAIT_SYNC) && (r_state != c_WAIT_SYNC))
        r_src_step <= r_pending;
      if (r_state != c_WAIT_TICK)
        r_period_cnt <= '0;
      else
        r_period_cnt <= r_period_cnt + PERIOD_WIDTH'(1);
    end
  end

`ifdef SILIFE_GEN_FRAME_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) r_frame_req <= 1'b0;
    else       r_frame_req <= (w_next_state == c_STEP) && i_frame_lock;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending         <= 1'b0;
      r_burst_remaining <= '0;
      r_gen_count       <= '0;
    end else begin
      // A request arriving while the flag is still set is dropped.
      if (i_abort)
        r_pending <= 1'b0;
      else if ((r_state == c_STEP) && r_src_step)
        r_pending <= 1'b0;
      else if (i_step)
        r_pending <= 1'b1;

      if (i_abort)
        r_burst_remaining <= '0;
      else if (i_burst_start)
        r_burst_remaining <= i_burst_len;
      else if ((r_state == c_STEP) && !r_src_step && (r_burst_remaining != '0))
        r_burst_remaining <= r_burst_remaining - BURST_WIDTH'(1);

      if (i_clear_count)
        r_gen_count <= '0;
      else if (r_state == c_STEP)
        r_gen_count <= r_gen_count + COUNT_WIDTH'(1);
    end
  end

  assign o_grid_enable     = r_grid_enable;
  assign o_busy            = r_busy;
  assign o_gen_count       = r_gen_count;
  assign o_burst_remaining = r_burst_remaining;

endmodule
`default_nettype wire

// File: doc/silife_gen_scheduler.md
# silife_gen_scheduler

Generation scheduler for the silife cell grid. It decides when the grid advances one generation and drives the grid's enable as single-cycle pulses. Steps come from free-running mode at a programmable period, single-step requests, and bounded bursts. Each step is held off while the inter-grid sync engine is busy and, optionally, until the MAX7219 display has finished a frame, so every generation is displayed before the next one.

## Interface
Parameters:
- PERIOD_WIDTH, 24, width of the step period in clk cycles
- BURST_WIDTH, 16, width of the burst step count
- COUNT_WIDTH, 32, width of the generation counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_run  in  1  level; free-running mode enable
- i_step  in  1  pulse; request one generation
- i_burst_start  in  1  pulse; load i_burst_len and run that many generations
- i_burst_len  in  BURST_WIDTH  burst length, sampled on i_burst_start
- i_abort  in  1  pulse; cancel the burst and any pending step
- i_period  in  PERIOD_WIDTH  cycles between period ticks; 0 is treated as 1
- i_frame_lock  in  1  level; wait for a display frame after each step
- i_sync_busy  in  1  inter-grid sync exchange in progress
- i_display_busy  in  1  MAX7219 frame transfer in progress
- i_clear_count  in  1  pulse; zero the generation counter
- o_grid_enable  out  1  one-cycle grid advance pulse
- o_frame_req  out  1  one-cycle display frame request
- o_gen_count  out  COUNT_WIDTH  generations executed, wraps at 2^COUNT_WIDTH
- o_burst_remaining  out  BURST_WIDTH  steps left in the current burst
- o_busy  out  1  high in every state except IDLE

## Operation
States:
- **IDLE**: no step source active.
- **WAIT_TICK**: waiting for the period counter.
- **WAIT_SYNC**: waiting for the sync engine and display to go idle.
- **STEP**: issues the grid advance pulse.
- **FRAME_RISE**: waiting for the display to start the frame.
- **FRAME_FALL**: waiting for the display to finish the frame.

Step sources:
- Pending step flag: set by i_step, one deep; extra requests while set are dropped.
- Period source: active when i_run=1 or o_burst_remaining≠0.

Transitions:
- IDLE -> WAIT_SYNC when the pending flag is set; this takes priority over the period source.
- IDLE -> WAIT_TICK when the period source is active; the period counter is cleared on entry.
- WAIT_TICK: the counter increments each cycle.
  - When the counter reaches max(i_period,1)-1, go to WAIT_SYNC.
  - If the pending flag is set, go to WAIT_SYNC immediately.
  - If the period source goes inactive, go to IDLE.
- WAIT_SYNC: stay while i_sync_busy=1, or while i_frame_lock=1 and i_display_busy=1; otherwise go to STEP.
- STEP, for exactly one cycle:
  - o_grid_enable=1 and o_gen_count increments.
  - The pending flag clears if it was the source; otherwise o_burst_remaining decrements if nonzero (saturating at 0).
  - With frame lock, o_frame_req=1 and the next state is FRAME_RISE; otherwise the next state is IDLE.
- FRAME_RISE -> FRAME_FALL on i_display_busy=1.
- FRAME_FALL -> IDLE on i_display_busy=0.

Boundary and simultaneous events:
- i_abort clears the pending flag and o_burst_remaining.
  - From WAIT_TICK or WAIT_SYNC it goes to IDLE; if STEP is already reached, that pulse still completes.
  - i_abort beats i_step and i_burst_start in the same cycle.
- i_burst_start while a burst is active reloads the count; i_burst_len=0 leaves no burst.
- i_clear_count in the same cycle as STEP: the counter becomes 0; clear wins over the increment.
- Dropping i_run mid-burst does not stop the burst.
- Reset mid-operation returns to IDLE immediately with all state cleared; no pulse is emitted in that cycle.

## Timing
- Reset values:
  - o_grid_enable=0, o_frame_req=0, o_gen_count=0, o_burst_remaining=0, o_busy=0.
  - State IDLE, pending flag 0, period counter 0.
- All outputs are registered.
- Single step, not busy: i_step at cycle N gives o_grid_enable at N+3 (flag at N+1, WAIT_SYNC at N+2, STEP at N+3).
- Free-running, no stalls: consecutive o_grid_enable pulses are i_period+3 cycles apart (period=0 gives 4).
- o_frame_req coincides with o_grid_enable.

## Configuration
- Macro `SILIFE_GEN_FRAME_LOCK_EN`.
- Defined: i_frame_lock behaves as specified, and FRAME_RISE/FRAME_FALL exist.
- Undefined:
  - i_frame_lock and i_display_busy are ignored and o_frame_req is tied 0.
  - STEP always returns to IDLE, and the FRAME states are not synthesized.

## Test plan
- Reset, then i_step once, no busy inputs -> one o_grid_enable at reset-release+3 after the step; o_gen_count=1; o_busy back to 0.
- i_run=1, i_period=5 for 100 cycles -> pulses every 8 cycles, o_gen_count=12; i_period=0 -> pulses every 4 cycles.
- i_burst_len=3, i_burst_start, i_period=2, i_run=0 -> exactly 3 pulses; o_burst_remaining steps 3,2,1,0; then IDLE.
- i_sync_busy held high for 20 cycles during WAIT_SYNC -> no pulse until 1 cycle after it drops; i_abort during the stall -> no pulse, IDLE.
- Macro defined, i_frame_lock=1, display model raising busy 2 cycles after o_frame_req for 10 cycles -> next pulse only after busy falls; macro undefined -> o_frame_req never asserted.
- o_gen_count at all-ones plus one step -> wraps to 0; i_clear_count during STEP -> 0.
